// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Holds default widths, reset PC, instruction size and the queue entry layout.
// Imported by fetch_unit and fetch_queue.
package fetch_unit_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          INST_BYTES   = 4;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  // One prefetch queue slot: PC in the upper half, instruction in the lower half.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: synchronous FIFO of DEPTH entries with push, pop and clear.
// Ports: push_i/push_dat_i write, pop_i advances head, clear_i empties, head_dat_o/count_o.
// Latency 1 cycle from push to visible head; the caller guarantees no push when full.
module fetch_queue #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [W-1:0]             push_dat_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  output logic [W-1:0]             head_dat_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PW'(1);
      if (pop_i)  rd_q <= rd_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_q];
  assign count_o    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited sequential fetch into a prefetch queue.
// Ports: imem_req_* request (valid/ready), imem_rsp_* in-order response, redirect_*, inst_* to decode.
// Response-to-decode latency 1 cycle; requests stall when queue plus in-flight reaches DEPTH.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int              CW   = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(INST_BYTES);

  logic            run_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   disc_q, disc_d;

  logic [CW-1:0]     q_count;
  logic [2*XLEN-1:0] q_head;
  logic              credit_ok, req_fire, rsp_drop, rsp_push, q_pop;

  // Credits come from registered state only, so the sole combinational
  // input to imem_req_valid is redirect_valid.
  assign credit_ok      = ({1'b0, q_count} + {1'b0, out_q}) < (CW+1)'(DEPTH);
  // run_q holds requests off during reset and for the first cycle after it.
  assign imem_req_valid = run_q && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (disc_q != '0);
  assign rsp_push = imem_rsp_valid && (disc_q == '0) && !redirect_valid;

  assign inst_valid = (q_count != '0);
  assign q_pop      = inst_valid && inst_ready && !redirect_valid;
  assign inst_pc    = inst_valid ? q_head[2*XLEN-1:XLEN] : '0;
  assign inst_data  = inst_valid ? q_head[XLEN-1:0]      : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    disc_d     = disc_q;
    out_d      = out_q + CW'(req_fire) - CW'(imem_rsp_valid);

    if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
    if (rsp_drop) disc_d     = disc_q - CW'(1);
    if (rsp_push) rsp_pc_d   = rsp_pc_q + STEP;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      rsp_pc_d   = redirect_pc & ~XLEN'(3);
      // No request can handshake in a redirect cycle, so everything still
      // outstanding after this cycle is stale and must be discarded.
      disc_d     = out_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
    end
  end

  fetch_queue #(
    .W     (2*XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_ni     (rst),
    .push_i     (rsp_push),
    .push_dat_i ({rsp_pc_q, imem_rsp_data}),
    .pop_i      (q_pop),
    .clear_i    (redirect_valid),
    .head_dat_o (q_head),
    .count_o    (q_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int lat   = 1;
  bit toggle_ready = 0;
  int nreq  = 0;
  int npop  = 0;
  logic [31:0] exp_pc = 32'h0;

  // Memory model: in-order queue of accepted addresses with their due cycle.
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic tick();
    logic        fire, rfire, popped;
    logic [31:0] addr;
    if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    imem_req_ready = toggle_ready ? ((cyc % 2) == 0) : 1'b1;
    #1;
    fire   = imem_req_valid && imem_req_ready;
    addr   = imem_req_addr;
    rfire  = imem_rsp_valid;
    popped = inst_valid && inst_ready && !redirect_valid;
    if (popped) begin
      check("pop_pc", inst_pc, exp_pc);
      check("pop_data", inst_data, memf(exp_pc));
      exp_pc += 32'd4;
      npop++;
    end
    check("credit_bound", 32'(mq_addr.size() <= DEPTH), 32'd1);
    @(posedge clk);
    if (rfire) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (fire) begin
      mq_addr.push_back(addr);
      mq_due.push_back(cyc + lat);
      nreq++;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Holds reset for two cycles, checks reset outputs, releases, and returns at
  // the first cycle in which a request may be issued.
  task automatic apply_reset();
    rst = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req_valid", imem_req_valid, 32'd0);
    check("rst_inst_valid", inst_valid, 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_req_addr", imem_req_addr, 32'd0);
    rst = 1'b1;
    tick();
  endtask

  initial begin
    clk = 0; rst = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    redirect_valid = 0; redirect_pc = 0; inst_ready = 0;

    // 1: latency 1, full throughput
    lat = 1; toggle_ready = 0; inst_ready = 1;
    apply_reset();
    exp_pc = 0; npop = 0;
    check("s1_first_valid", imem_req_valid, 32'd1);
    check("s1_first_addr", imem_req_addr, 32'h0);
    tick();
    check("s1_second_addr", imem_req_addr, 32'h4);
    check("s1_not_yet", inst_valid, 32'd0);
    tick();
    check("s1_inst_valid", inst_valid, 32'd1);
    check("s1_inst_pc", inst_pc, 32'h0);
    for (int i = 0; i < 6; i++) tick();
    check("s1_throughput", npop, 32'd6);

    // 2: decode stalled, credits exhaust at DEPTH
    inst_ready = 0;
    apply_reset();
    nreq = 0;
    for (int i = 0; i < 10; i++) tick();
    check("s2_nreq", nreq, 32'd4);
    check("s2_req_stalled", imem_req_valid, 32'd0);
    check("s2_head_pc", inst_pc, 32'h0);
    check("s2_head_data", inst_data, memf(32'h0));
    inst_ready = 1; exp_pc = 0; npop = 0;
    tick();
    check("s2_resume_valid", imem_req_valid, 32'd1);
    check("s2_resume_addr", imem_req_addr, 32'h10);
    for (int i = 0; i < 8; i++) tick();
    check("s2_drain_pops", npop, 32'd9);

    // 3: latency 3 with ready toggling
    lat = 3; toggle_ready = 1; inst_ready = 1;
    apply_reset();
    exp_pc = 0; npop = 0;
    for (int i = 0; i < 40; i++) tick();
    check("s3_progress", 32'(npop >= 8), 32'd1);

    // 4: redirect with three fetches in flight
    lat = 3; toggle_ready = 0; inst_ready = 1;
    apply_reset();
    exp_pc = 0; npop = 0;
    tick(); tick(); tick();
    redirect_valid = 1; redirect_pc = 32'h100;
    #1;
    check("s4_req_blocked", imem_req_valid, 32'd0);
    tick();
    redirect_valid = 0;
    exp_pc = 32'h100; npop = 0;
    #1;
    check("s4_q_empty", inst_valid, 32'd0);
    check("s4_new_addr", imem_req_addr, 32'h100);
    check("s4_new_valid", imem_req_valid, 32'd1);
    tick();
    check("s4_stale1", inst_valid, 32'd0);
    tick();
    check("s4_stale2", inst_valid, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    check("s4_pops", 32'(npop >= 3), 32'd1);

    // 5: redirect colliding with response and pop, then a second redirect
    lat = 1; toggle_ready = 0; inst_ready = 1;
    apply_reset();
    exp_pc = 0; npop = 0;
    for (int i = 0; i < 4; i++) tick();
    redirect_valid = 1; redirect_pc = 32'h203;
    #1;
    check("s5_head_before", inst_valid, 32'd1);
    tick();
    check("s5_flushed", inst_valid, 32'd0);
    check("s5_aligned_addr", imem_req_addr, 32'h200);
    redirect_pc = 32'h400;
    #1;
    check("s5_req_blocked", imem_req_valid, 32'd0);
    tick();
    redirect_valid = 0;
    exp_pc = 32'h400; npop = 0;
    #1;
    check("s5_addr_400", imem_req_addr, 32'h400);
    check("s5_valid_400", imem_req_valid, 32'd1);
    check("s5_empty_400", inst_valid, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    check("s5_pops", npop, 32'd6);

    // 6: reset mid-stream with two entries queued
    lat = 1; inst_ready = 0;
    apply_reset();
    tick(); tick(); tick();
    check("s6_queued", inst_valid, 32'd1);
    check("s6_queued_pc", inst_pc, 32'h0);
    rst = 0;
    #1;
    check("s6_async_inst", inst_valid, 32'd0);
    check("s6_async_req", imem_req_valid, 32'd0);
    apply_reset();
    check("s6_restart_addr", imem_req_addr, 32'h0);
    check("s6_restart_valid", imem_req_valid, 32'd1);
    inst_ready = 1; exp_pc = 0; npop = 0;
    for (int i = 0; i < 6; i++) tick();
    check("s6_pops", npop, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation core; replaces the single-cycle PC register / +4 adder / PC select / direct IMEM read path.
- Issues sequential fetch requests to an instruction memory with variable latency (valid/ready request, in-order valid response).
- Buffers returned instructions with their PCs in a prefetch queue that feeds decode.
- Redirect input from execute (branch/jump) flushes queued and in-flight fetches and restarts at the new PC.

Parameters:
XLEN, 32, address/instruction width
DEPTH, 4, prefetch queue entries and max in-flight credits; power of 2, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  fetch address, word aligned
imem_rsp_valid  input  1  response valid; in request order; latency >= 1 cycle
imem_rsp_data  input  XLEN  fetched instruction
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  XLEN  restart address
inst_valid  output  1  queue head valid
inst_ready  input  1  decode consumes head
inst_data  output  XLEN  head instruction
inst_pc  output  XLEN  PC of head instruction

Behaviour:
- Reset (rst low, async): fetch_pc=RESET_PC, rsp_pc=RESET_PC, queue empty, outstanding=0, discard=0; imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
- Credit rule: imem_req_valid = !redirect_valid && (count + outstanding < DEPTH), from registered values only; count, outstanding, discard are clog2(DEPTH)+1 bits.
- imem_req_addr = fetch_pc; request handshake (valid & ready) -> fetch_pc += 4 (wraps modulo 2^XLEN), outstanding +1.
- Response (imem_rsp_valid): outstanding -1; if discard > 0, drop, discard -1; else push {rsp_pc, imem_rsp_data}, rsp_pc += 4.
- Request and response in same cycle: outstanding unchanged.
- Response-to-output latency: 1 cycle (queue registered, no bypass).
- Outputs: inst_valid = count != 0; inst_data/inst_pc = head entry; pop on inst_valid & inst_ready.
- Push and pop same cycle: count unchanged. Credit rule guarantees no push when full; a response arriving with the queue full is a protocol violation, and the bench flags it as an assertion failure.
- Redirect (takes priority over everything that cycle): queue cleared (the same-cycle pop is ignored); fetch_pc = rsp_pc = {redirect_pc[XLEN-1:2], 2'b00}; the same-cycle response is dropped; discard = outstanding - imem_rsp_valid + discard_adjust, where discard_adjust makes all responses still in flight be dropped. New-PC request visible at cycle t+1 when credits allow.
- Back-to-back redirects: the last one wins; discard is recomputed each time.
- Reset mid-operation: all state cleared immediately. The memory must be reset by the same rst; stale responses are not tracked.
- No combinational path from imem_rsp_* to inst_* outputs; the only combinational input to imem_req_valid is redirect_valid.

Decomposition:
- Shared package: XLEN default, RESET_PC default, INST_BYTES=4, NOP encoding 32'h0000_0013, queue entry typedef {pc, inst}.
- One sub-module: fetch_queue, a synchronous FIFO (DEPTH entries of 2*XLEN) with push/pop/clear, count output, and pointer wrap on power-of-2 depth.

Test Plan:
- Reset release, memory latency 1, ready=1, inst_ready=1 -> requests 0x0,0x4,0x8…; inst_pc 0x0 first valid 2 cycles after first request; steady throughput 1 instruction/cycle.
- inst_ready=0, DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0; raise inst_ready -> drains 0x0..0xC in order, fetching resumes at 0x10.
- Memory latency 3, ready toggling 1/0 -> no duplicate or skipped PCs; inst_data matches memory model at each inst_pc.
- Redirect to 0x100 with 3 in flight, latency 3 -> 3 stale responses dropped, queue empty the next cycle, next inst_pc = 0x100 with correct data.
- Redirect to 0x203 in the same cycle as a response and a pop -> response dropped, fetch at 0x200; redirect again to 0x400 the next cycle -> only 0x400 stream appears.
- Assert rst mid-stream with 2 queued -> inst_valid=0 immediately; after release, fetch restarts at RESET_PC.
